// File: rtl/tlc_apb_master.sv
// Autonomous APB requester for the two-road traffic-light slave. It reads STATE,
// dwells for a time set by the lamp phase, and then writes NEXT to advance the sequence.
module tlc_apb_master #(
    parameter logic [15:0] GREEN_TICKS  = 16'd20,
    parameter logic [15:0] YELLOW_TICKS = 16'd5,
    parameter logic [15:0] ALLRED_TICKS = 16'd3,
    parameter logic [7:0]  TIMEOUT      = 8'd16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        enable,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic [2:0]  lamp_a,
    output logic [2:0]  lamp_b,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_SETUP, S_RD_ACCESS, S_DWELL,
        S_WR_SETUP, S_WR_ACCESS, S_GAP, S_ERR
    } state_e;

    localparam logic [2:0]  LAMP_G    = 3'b100;
    localparam logic [2:0]  LAMP_Y    = 3'b010;
    localparam logic [2:0]  LAMP_R    = 3'b001;
    localparam logic [31:0] ADDR_STATE = 32'h0000_0000;
    localparam logic [31:0] ADDR_CTRL  = 32'h0000_0004;
    localparam logic [31:0] CTRL_NEXT  = 32'h0000_0001;

    state_e      state_q, state_d;
    logic [15:0] dwell_q, dwell_d;
    logic [7:0]  tmo_q, tmo_d, tmo_inc;
    logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic [2:0]  lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
    logic        err_q, err_d, busy_q, busy_d;

    logic [2:0]  rd_a, rd_b;
    logic [15:0] dwell_sel;
    logic        dwell_ok;
    logic        unused_prdata;

    assign rd_a          = prdata[2:0];
    assign rd_b          = prdata[18:16];
    assign unused_prdata = ^{prdata[31:19], prdata[15:3]};
    assign tmo_inc       = tmo_q + 8'd1;

    // Only the five legal phase pairs get a dwell time; anything else is a slave fault.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        dwell_sel = '0;
        dwell_ok  = 1'b1;
        if ((rd_a == LAMP_G && rd_b == LAMP_R) || (rd_a == LAMP_R && rd_b == LAMP_G))
            dwell_sel = GREEN_TICKS;
        else if ((rd_a == LAMP_Y && rd_b == LAMP_R) || (rd_a == LAMP_R && rd_b == LAMP_Y))
            dwell_sel = YELLOW_TICKS;
        else if (rd_a == LAMP_R && rd_b == LAMP_R)
            dwell_sel = ALLRED_TICKS;
        else
            dwell_ok = 1'b0;
    end

    always_comb begin
        state_d  = state_q;
        dwell_d  = dwell_q;
        tmo_d    = tmo_q;
        lamp_a_d = lamp_a_q;
        lamp_b_d = lamp_b_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE:      if (enable) state_d = S_RD_SETUP;
            S_RD_SETUP: begin
                tmo_d   = '0;
                state_d = S_RD_ACCESS;
            end
            S_RD_ACCESS: begin
                if (pready) begin
                    if (!pslverr && dwell_ok) begin
                        lamp_a_d = rd_a;
                        lamp_b_d = rd_b;
                        dwell_d  = dwell_sel;
                        state_d  = S_DWELL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_DWELL: begin
                dwell_d = dwell_q - 16'd1;
                if (dwell_q == 16'd1) state_d = S_WR_SETUP;
            end
            S_WR_SETUP: begin
                tmo_d   = '0;
                state_d = S_WR_ACCESS;
            end
            S_WR_ACCESS: begin
                if (pready) begin
                    if (pslverr) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TIMEOUT) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_GAP:       state_d = enable ? S_RD_SETUP : S_IDLE;
            S_ERR:       if (!enable) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        psel_d    = (state_d == S_RD_SETUP) || (state_d == S_RD_ACCESS) ||
                    (state_d == S_WR_SETUP) || (state_d == S_WR_ACCESS);
        penable_d = (state_d == S_RD_ACCESS) || (state_d == S_WR_ACCESS);
        busy_d    = (state_d != S_IDLE) && (state_d != S_ERR);
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        if (state_d == S_RD_SETUP) begin
            pwrite_d = 1'b0;
            paddr_d  = ADDR_STATE;
        end else if (state_d == S_WR_SETUP) begin
            pwrite_d = 1'b1;
            paddr_d  = ADDR_CTRL;
            pwdata_d = CTRL_NEXT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= S_IDLE;
            dwell_q   <= '0;
            tmo_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            lamp_a_q  <= LAMP_G;
            lamp_b_q  <= LAMP_R;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            tmo_q     <= tmo_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            lamp_a_q  <= lamp_a_d;
            lamp_b_q  <= lamp_b_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign lamp_a  = lamp_a_q;
    assign lamp_b  = lamp_b_q;
    assign err     = err_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_tlc_apb_master.sv
// Directed bench for tlc_apb_master: a behavioural traffic-light APB slave with
// selectable wait/error behaviour, a negedge bus monitor, and hand-derived expectations.
module tb_tlc_apb_master;

    logic        pclk = 1'b0;
    logic        presetn, enable;
    logic        psel, penable, pwrite, pready, pslverr, err, busy;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  lamp_a, lamp_b;

    // Slave behaviour: 0 = one wait state, 1 = pready tied high, 2 = never ready
    logic [1:0]  mode;
    logic        wr_err_mode, bad_data_mode, clr;

    localparam logic [31:0] STATE_TAB [6] = '{32'h0001_0004, 32'h0001_0002, 32'h0001_0001,
                                              32'h0004_0001, 32'h0002_0001, 32'h0001_0001};
    localparam logic [2:0]  EXP_A [7] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001, 3'b100};
    localparam logic [2:0]  EXP_B [7] = '{3'b001, 3'b001, 3'b001, 3'b100, 3'b010, 3'b001, 3'b001};
    localparam int          EXP_DW [6] = '{20, 5, 3, 20, 5, 3};

    always #5 pclk = ~pclk;

    tlc_apb_master dut (
        .pclk    (pclk),
        .presetn (presetn),
        .enable  (enable),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .lamp_a  (lamp_a),
        .lamp_b  (lamp_b),
        .err     (err),
        .busy    (busy)
    );

    // Traffic-light slave model
    int unsigned ph_q;
    logic        wait_seen_q;

    assign pready  = (mode == 2'd1) ? 1'b1 : ((mode == 2'd0) ? wait_seen_q : 1'b0);
    assign prdata  = bad_data_mode ? 32'h0004_0004 : STATE_TAB[ph_q];
    assign pslverr = wr_err_mode && pwrite && psel && penable && pready;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ph_q        <= 0;
            wait_seen_q <= 1'b0;
        end else begin
            wait_seen_q <= psel && penable && !pready;
            if (psel && penable && pready && pwrite && !pslverr && paddr == 32'h4 && pwdata[0])
                ph_q <= (ph_q == 5) ? 0 : ph_q + 1;
        end
    end

    // Bus monitor and protocol checker
    int          cyc = 0;
    int          n_acc = 0;
    int          viol = 0;
    int          rd_start[$], rd_done[$], wr_setup[$], wr_done[$];
    logic [31:0] rd_data[$], rd_addr[$], wr_addr[$], wr_data[$];
    logic [5:0]  lamp_log[$];
    logic        lamp_pend = 1'b0;
    logic        prev_psel = 1'b0, prev_penable = 1'b0, prev_ready = 1'b0, prev_pwrite = 1'b0;
    logic [31:0] prev_paddr = '0;

    always @(negedge pclk) begin
        if (clr) begin
            rd_start.delete(); rd_done.delete(); wr_setup.delete(); wr_done.delete();
            rd_data.delete(); rd_addr.delete(); wr_addr.delete(); wr_data.delete();
            lamp_log.delete();
            n_acc     <= 0;
            viol      <= 0;
            lamp_pend <= 1'b0;
        end else begin
            if (lamp_pend) lamp_log.push_back({lamp_a, lamp_b});
            lamp_pend <= psel && penable && pready && !pwrite && !pslverr;
            if (psel && !penable && !pwrite) rd_start.push_back(cyc);
            if (psel && !penable && pwrite)  wr_setup.push_back(cyc);
            if (psel && penable && pready && !pwrite) begin
                rd_done.push_back(cyc);
                rd_data.push_back(prdata);
                rd_addr.push_back(paddr);
            end
            if (psel && penable && pready && pwrite) begin
                wr_done.push_back(cyc);
                wr_addr.push_back(paddr);
                wr_data.push_back(pwdata);
            end
            if (psel && penable) n_acc <= n_acc + 1;
            if (presetn && ((penable && !prev_psel) || (penable && !psel) ||
                            (prev_psel && !prev_penable && !(psel && penable)) ||
                            (prev_psel && prev_penable && !prev_ready &&
                             (paddr != prev_paddr || pwrite != prev_pwrite))))
                viol <= viol + 1;
        end
        cyc          <= cyc + 1;
        prev_psel    <= psel;
        prev_penable <= penable;
        prev_ready   <= pready;
        prev_pwrite  <= pwrite;
        prev_paddr   <= paddr;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge pclk);
        #1;
    endtask

    task automatic do_reset();
        presetn = 1'b0;
        enable  = 1'b0;
        clr     = 1'b1;
        repeat (3) tick();
        clr     = 1'b0;
        presetn = 1'b1;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        presetn = 1'b0; enable = 1'b0; clr = 1'b1;
        mode = 2'd0; wr_err_mode = 1'b0; bad_data_mode = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_paddr", paddr, 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_lamp_a", lamp_a, 3'b100);
        check("rst_lamp_b", lamp_b, 3'b001);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Six full loops against the one-wait slave, then drop enable mid-dwell
        do_reset();
        enable = 1'b1;
        tick(); tick();
        check("run_busy", busy, 1'b1);
        b = 0;
        while (lamp_log.size() < 7 && b < 400) begin tick(); b++; end
        check("run_reached_7_reads", lamp_log.size() >= 7, 1'b1);
        enable = 1'b0;
        b = 0;
        while (busy && b < 100) begin tick(); b++; end
        check("run_idle_after_drop", busy, 1'b0);
        check("run_rd_addr", rd_addr[0], 32'h0);
        check("run_rd0_data", rd_data[0], 32'h0001_0004);
        check("run_rd1_data", rd_data[1], 32'h0001_0002);
        for (int i = 0; i < 7; i++)
            check($sformatf("run_lamps_%0d", i), lamp_log[i], {EXP_A[i], EXP_B[i]});
        for (int i = 0; i < 6; i++) begin
            check($sformatf("run_dwell_%0d", i), wr_setup[i] - rd_done[i] - 1, EXP_DW[i]);
            check($sformatf("run_period_%0d", i), rd_start[i+1] - rd_start[i], EXP_DW[i] + 7);
            check($sformatf("run_wr_addr_%0d", i), wr_addr[i], 32'h4);
            check($sformatf("run_wr_data_%0d", i), wr_data[i], 32'h1);
        end
        check("drop_reads", rd_start.size(), 7);
        check("drop_writes", wr_done.size(), 7);
        check("run_err", err, 1'b0);
        check("run_proto", viol, 0);

        // Zero-wait slave: period N+5
        do_reset();
        mode = 2'd1;
        enable = 1'b1;
        b = 0;
        while (rd_start.size() < 4 && b < 200) begin tick(); b++; end
        check("zw_reached", rd_start.size() >= 4, 1'b1);
        check("zw_period_0", rd_start[1] - rd_start[0], 25);
        check("zw_period_1", rd_start[2] - rd_start[1], 10);
        check("zw_period_2", rd_start[3] - rd_start[2], 8);
        check("zw_dwell_0", wr_setup[0] - rd_done[0] - 1, 20);
        check("zw_proto", viol, 0);
        enable = 1'b0;
        b = 0;
        while (busy && b < 100) begin tick(); b++; end

        // pslverr on the write
        do_reset();
        mode = 2'd0; wr_err_mode = 1'b1;
        enable = 1'b1;
        b = 0;
        while (!(psel && penable && pready && pslverr) && b < 100) begin tick(); b++; end
        check("slverr_seen", psel && penable && pready && pslverr, 1'b1);
        tick();
        check("slverr_err", err, 1'b1);
        check("slverr_psel", psel, 1'b0);
        check("slverr_penable", penable, 1'b0);
        check("slverr_busy", busy, 1'b0);
        repeat (3) tick();
        check("slverr_hold_in_err", psel, 1'b0);
        enable = 1'b0;
        tick(); tick();
        check("slverr_idle_err", err, 1'b1);
        check("slverr_idle_busy", busy, 1'b0);
        enable = 1'b1;
        tick(); tick();
        check("slverr_restart_psel", psel, 1'b1);
        check("slverr_restart_err", err, 1'b1);
        wr_err_mode = 1'b0;

        // pready never asserted: timeout after 16 ACCESS cycles
        do_reset();
        mode = 2'd2;
        enable = 1'b1;
        b = 0;
        while (!err && b < 60) begin tick(); b++; end
        check("tmo_err", err, 1'b1);
        check("tmo_access_cycles", n_acc, 16);
        check("tmo_psel", psel, 1'b0);
        check("tmo_penable", penable, 1'b0);

        // Illegal lamp encoding: both roads green
        do_reset();
        mode = 2'd0; bad_data_mode = 1'b1;
        enable = 1'b1;
        b = 0;
        while (!err && b < 30) begin tick(); b++; end
        check("bad_err", err, 1'b1);
        repeat (5) tick();
        check("bad_no_write", wr_setup.size(), 0);
        check("bad_psel", psel, 1'b0);
        check("bad_lamp_a_kept", lamp_a, 3'b100);
        check("bad_lamp_b_kept", lamp_b, 3'b001);
        bad_data_mode = 1'b0;

        // Asynchronous reset during WR_ACCESS
        do_reset();
        mode = 2'd0;
        enable = 1'b1;
        b = 0;
        while (!(psel && penable && pwrite) && b < 100) begin tick(); b++; end
        check("arst_in_wr_access", psel && penable && pwrite, 1'b1);
        presetn = 1'b0;
        #1;
        check("arst_psel", psel, 1'b0);
        check("arst_penable", penable, 1'b0);
        check("arst_pwrite", pwrite, 1'b0);
        check("arst_paddr", paddr, 32'h0);
        check("arst_pwdata", pwdata, 32'h0);
        check("arst_lamp_a", lamp_a, 3'b100);
        check("arst_lamp_b", lamp_b, 3'b001);
        check("arst_err", err, 1'b0);
        check("arst_busy", busy, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        presetn = 1'b1;
        b = 0;
        while (rd_start.size() + wr_setup.size() == 0 && b < 10) begin tick(); b++; end
        check("arst_restart_read", rd_start.size(), 1);
        check("arst_restart_no_write", wr_setup.size(), 0);
        enable = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
